// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, keeps exactly one
// request outstanding to instruction memory, and presents {pc, instr}
// to the IF/ID register. Honours the IF/ID stall and branch/jump
// redirects, and drops any response that belongs to a pre-redirect PC.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   stall               IF/ID hold request from hazard logic
//   redirect_valid/pc   taken branch/jump and its target (low 2 bits ignored)
//   imem_req/addr       fetch request and aligned byte address
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid/rdata   fetch response (one per accepted request)
//   if_pc/instruction   toward IF/ID; 0/NOP_WORD when fetch_valid=0
//   fetch_valid         if_pc/if_instruction hold a real instruction
//   if_id_flush         copy of redirect_valid for the IF/ID flush input
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        fetch_valid,
    output logic        if_id_flush
);

    localparam logic [1:0] S_REQ     = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    localparam logic [31:0] STEP = 32'(PC_STEP);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] held_pc_q, held_pc_d;
    logic [31:0] held_instr_q, held_instr_d;
    logic        valid_q, valid_d;
    logic [31:0] redirect_target;

    assign redirect_target = redirect_pc & ~32'h3;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        held_pc_d    = held_pc_q;
        held_instr_d = held_instr_q;
        valid_d      = valid_q;

        // A redirect always retargets the PC and kills whatever is held;
        // the state choice below only decides what happens to the
        // request that may be in flight.
        if (redirect_valid) begin
            pc_d    = redirect_target;
            valid_d = 1'b0;
        end

        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    // An accepted request now fetches a stale PC.
                    state_d = imem_gnt ? S_DISCARD : S_REQ;
                end else if (imem_gnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? S_REQ : S_DISCARD;
                end else if (imem_rvalid) begin
                    held_instr_d = imem_rdata;
                    held_pc_d    = pc_q;
                    pc_d         = pc_q + STEP;
                    valid_d      = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || !stall) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            held_pc_q    <= 32'h0;
            held_instr_q <= NOP_WORD;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            held_pc_q    <= held_pc_d;
            held_instr_q <= held_instr_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req       = (state_q == S_REQ);
    assign imem_addr      = pc_q;
    assign fetch_valid    = valid_q;
    assign if_pc          = valid_q ? held_pc_q : 32'h0;
    assign if_instruction = valid_q ? held_instr_q : NOP_WORD;
    assign if_id_flush    = redirect_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model of the fetch stage and a simple memory.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] DEAD   = 32'h0000_DEAD;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        fetch_valid;
    logic        if_id_flush;

    fetch_unit #(
        .RESET_PC (RST_PC),
        .PC_STEP  (4),
        .NOP_WORD (NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .fetch_valid    (fetch_valid),
        .if_id_flush    (if_id_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: architectural next-fetch PC, the in-flight request (and
    // whether a redirect made it stale), and the presented instruction.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_out_pc = 32'h0;
    logic [31:0] m_hold_pc = 32'h0;
    logic [31:0] m_hold_instr = 32'h0;
    bit          m_out = 1'b0;
    bit          m_stale = 1'b0;
    bit          m_hold = 1'b0;
    bit          armed = 1'b0;

    // Memory: one pending response with a countdown.
    bit          mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'h0;
    bit          force_dead = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, check, update at posedge.
    task automatic tick(input bit rst, input bit st, input bit rv,
                        input logic [31:0] rpc, input bit g,
                        input int lat);
        bit          exp_req;
        bit          act_req;
        bit          resp;
        bit          acc;
        bit          mresp;
        logic [31:0] act_addr;
        reset          = rst;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_gnt       = g;
        imem_rvalid    = mem_busy && (mem_cnt == 0);
        imem_rdata     = imem_rvalid ? mem_data : $urandom;
        #1;
        exp_req = !m_out && !m_hold;
        if (armed) begin
            chk("flush", {31'h0, if_id_flush}, {31'h0, rv});
            chk("req", {31'h0, imem_req}, {31'h0, exp_req});
            if (exp_req) chk("addr", imem_addr, m_pc);
            chk("valid", {31'h0, fetch_valid}, {31'h0, m_hold});
            chk("pc", if_pc, m_hold ? m_hold_pc : 32'h0);
            chk("instr", if_instruction, m_hold ? m_hold_instr : NOP);
        end
        act_req  = imem_req;
        act_addr = imem_addr;
        resp     = imem_rvalid;
        @(posedge clk);
        if (rst) begin
            mem_busy = 1'b0;
        end else begin
            if (resp) mem_busy = 1'b0;
            else if (mem_busy && mem_cnt > 0) mem_cnt--;
            if (act_req && g) begin
                mem_busy = 1'b1;
                mem_cnt  = lat - 1;
                mem_data = force_dead ? DEAD : act_addr + 32'h100;
            end
        end
        if (rst) begin
            m_pc   = RST_PC;
            m_out  = 1'b0;
            m_hold = 1'b0;
            armed  = 1'b1;
        end else begin
            acc   = exp_req && g;
            mresp = m_out && resp;
            if (rv) begin
                m_pc   = rpc & ~32'h3;
                m_hold = 1'b0;
                if (acc) begin
                    m_out   = 1'b1;
                    m_stale = 1'b1;
                end else if (mresp) begin
                    m_out = 1'b0;
                end else if (m_out) begin
                    m_stale = 1'b1;
                end
            end else begin
                if (m_hold && !st) m_hold = 1'b0;
                if (acc) begin
                    m_out    = 1'b1;
                    m_stale  = 1'b0;
                    m_out_pc = m_pc;
                end
                if (mresp) begin
                    m_out = 1'b0;
                    if (!m_stale) begin
                        m_hold       = 1'b1;
                        m_hold_pc    = m_out_pc;
                        m_hold_instr = m_out_pc + 32'h100;
                        m_pc         = m_out_pc + 32'h4;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 32'h0, 1, 1);
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 32'h0, 0, 1);
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        @(negedge clk);

        // Straight-line fetch: 0,4,8 with 1-cycle memory.
        do_reset();
        do_reset();
        run(9);

        // Stall for 5 cycles while pc=4 is held.
        do_reset();
        n = 0;
        while (n < 20 && !(m_hold && m_hold_pc == 32'h4)) begin
            run(1);
            n++;
        end
        chk("t2_reach", {31'h0, m_hold && m_hold_pc == 32'h4}, 32'h1);
        for (int i = 0; i < 5; i++) tick(0, 1, 0, 32'h0, 1, 1);
        run(4);

        // Redirect during WAIT; stale 0xDEAD arrives 3 cycles later.
        do_reset();
        force_dead = 1'b1;
        tick(0, 0, 0, 32'h0, 1, 4);
        force_dead = 1'b0;
        tick(0, 0, 1, 32'h40, 0, 1);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 0, 32'h0, 1, 1);
            chk("t3_dead", {31'h0, if_instruction == DEAD}, 32'h0);
        end

        // Redirect with stall while holding.
        do_reset();
        n = 0;
        while (n < 20 && !m_hold) begin
            run(1);
            n++;
        end
        chk("t4_reach", {31'h0, m_hold}, 32'h1);
        tick(0, 1, 1, 32'h83, 1, 1);
        run(4);

        // PC wrap from FFFF_FFFC.
        do_reset();
        tick(0, 0, 1, 32'hFFFF_FFFC, 0, 1);
        run(5);

        // Reset during WAIT.
        do_reset();
        tick(0, 0, 0, 32'h0, 1, 3);
        do_reset();
        run(3);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 3,
                 $urandom_range(0, 9) == 0,
                 $urandom,
                 $urandom_range(0, 9) < 6,
                 int'($urandom_range(1, 4)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
